// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage state encoding, NOP encoding and default reset vector
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD, FAULT} fetch_state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry {instr, pc} holding register with load/drain/clear
module fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            full
);
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch and IF/ID register; MISALIGN_CHECK_EN enables misaligned-redirect fault
module fetch_stage import fetch_pkg::*; #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            Stall,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemGnt,
  input  logic            ImemValid,
  input  logic [31:0]     ImemRdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchFault
);
  fetch_state_t    state;
  logic [XLEN-1:0] pcf, req_pc, buf_pc, d_pc;
  logic [31:0]     buf_instr;
  logic            buf_full, deliver, grant, fault_redirect;
  assign deliver  = state == WAIT && ImemValid;
  assign ImemReq  = rst_n && !PCSrc && !Stall && !buf_full && (state == IDLE || deliver);
  assign ImemAddr = pcf;
  assign grant    = ImemReq && ImemGnt;
  assign d_pc     = deliver ? req_pc : buf_pc;
`ifdef MISALIGN_CHECK_EN
  logic fault_q;
  assign fault_redirect = PCSrc && |PCTarget[1:0];
  assign FetchFault     = fault_q;
  always_ff @(posedge clk) begin
    fault_q <= rst_n && (fault_q || fault_redirect);
  end
`else
  assign fault_redirect = 1'b0;
  assign FetchFault     = 1'b0;
`endif
  fetch_buffer #(.XLEN(XLEN)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (!PCSrc && deliver && Stall),
    .drain    (!PCSrc && !Stall && buf_full),
    .clear    (PCSrc),
    .instr_in (ImemRdata),
    .pc_in    (req_pc),
    .instr    (buf_instr),
    .pc       (buf_pc),
    .full     (buf_full)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcf      <= RESET_VECTOR;
      req_pc   <= RESET_VECTOR;
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (fault_redirect) begin
      state  <= FAULT;
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (PCSrc) begin
      pcf    <= PCTarget & ~XLEN'(3);
      state  <= state == FAULT ? FAULT :
                (state == WAIT || state == DISCARD) && !ImemValid ? DISCARD : IDLE;
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else begin
      if (grant) begin
        pcf    <= pcf + XLEN'(4);
        req_pc <= pcf;
      end
      state <= grant ? WAIT : (state == WAIT || state == DISCARD) && ImemValid ? IDLE : state;
      if (!Stall) begin
        ValidD <= deliver || buf_full;
        InstrD <= deliver ? ImemRdata : buf_full ? buf_instr : NOP;
        if (deliver || buf_full) begin
          PCD      <= d_pc;
          PCPlus4D <= d_pc + XLEN'(4);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch-stage bench against an instruction-stream reference model
module tb_fetch_stage;
  localparam logic [31:0] RV  = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst_n = 1'b0, PCSrc = 1'b0, Stall = 1'b0;
  logic        ImemGnt = 1'b0, ImemValid = 1'b0;
  logic [31:0] PCTarget = '0, ImemRdata = '0;
  logic        ImemReq, ValidD, FetchFault;
  logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
  int checks = 0, errors = 0;
  bit pend, killed, buffered, faulted;
  bit prev_stall, prev_pcsrc, prev_req, prev_gnt, prev_valid;
  int cnt, idle;
  logic [31:0] pend_addr, exp_pc, req_exp, prev_addr, prev_instr, prev_pcd;

  fetch_stage #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall(Stall),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt), .ImemValid(ImemValid),
    .ImemRdata(ImemRdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchFault(FetchFault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    if (obs !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expected, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; PCSrc = 0; Stall = 0; ImemGnt = 0; ImemValid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", ImemReq, 0);
    check("rst_addr", ImemAddr, RV);
    check("rst_instr", InstrD, NOP);
    check("rst_pcd", PCD, 0);
    check("rst_pcp4", PCPlus4D, 0);
    check("rst_valid", ValidD, 0);
    check("rst_fault", FetchFault, 0);
    pend = 0; killed = 0; buffered = 0; faulted = 0; idle = 0;
    exp_pc = RV; req_exp = RV;
    prev_stall = 0; prev_pcsrc = 0; prev_req = 0; prev_gnt = 0; prev_valid = 0;
  endtask

  task automatic step(input bit gnt, input bit stall, input bit pcsrc,
                      input logic [31:0] tgt, input int lat);
    bit live;
    @(negedge clk);
    rst_n = 1; ImemGnt = gnt; Stall = stall; PCSrc = pcsrc; PCTarget = tgt;
    ImemValid = 0; ImemRdata = $urandom; live = 0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        ImemValid = 1; ImemRdata = mem_word(pend_addr); pend = 0; live = !killed;
      end
    end
    #1;
    check("fault_flag", FetchFault, faulted);
    if (faulted) begin
      check("fault_req", ImemReq, 0);
      check("fault_valid", ValidD, 0);
      return;
    end
    if (prev_pcsrc) begin
      check("redir_valid", ValidD, 0);
    end else if (prev_stall) begin
      check("hold_valid", ValidD, prev_valid);
      if (prev_valid) begin
        check("hold_pcd", PCD, prev_pcd);
        check("hold_instr", InstrD, prev_instr);
      end
    end
    if (!ValidD) check("nop", InstrD, NOP);
    else begin
      check("instr", InstrD, mem_word(PCD));
      check("pcplus4", PCPlus4D, PCD + 32'd4);
    end
    if (!stall && !pcsrc) begin
      if (ValidD) begin
        check("seq_pc", PCD, exp_pc);
        exp_pc += 4; idle = 0;
      end else if (++idle > 40) begin
        check("progress_timeout", idle, 0);
        idle = 0;
      end
    end
    if (stall || pcsrc || buffered) check("req_blocked", ImemReq, 0);
    if (ImemReq) check("req_addr", ImemAddr, req_exp);
    if (prev_req && !prev_gnt && !stall && !pcsrc) begin
      check("req_stable", ImemReq, 1);
      check("addr_stable", ImemAddr, prev_addr);
    end
    if (ImemReq && gnt) begin
      check("one_outstanding", pend, 0);
      pend = 1; killed = 0; pend_addr = ImemAddr; cnt = lat; req_exp += 4;
    end
    buffered = pcsrc ? 0 : (live && stall) ? 1 : stall ? buffered : 0;
    if (pcsrc) begin
      if (pend) killed = 1;
      exp_pc = tgt & ~32'd3; req_exp = tgt & ~32'd3;
`ifdef MISALIGN_CHECK_EN
      faulted = |tgt[1:0];
`endif
    end
    prev_stall = stall; prev_pcsrc = pcsrc; prev_req = ImemReq; prev_gnt = gnt;
    prev_addr = ImemAddr; prev_valid = ValidD; prev_instr = InstrD; prev_pcd = PCD;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 1);
      if (ValidD) return;
    end
    check("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0, 0, 1);
      check("startup_valid", ValidD, k >= 3);
    end
    repeat (3) step(1, 1, 0, 0, 1);
    check("stall_noreq", ImemReq, 0);
    repeat (4) step(1, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10 && !pend; i++) step(1, 0, 0, 0, 3);
    step(1, 0, 1, 32'h100, 1);
    wait_valid();
    check("redirect_pcd", PCD, 32'h100);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'h0000_0FFC);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
           t, $urandom_range(1, 3));
    end
    repeat (4) step(1, 0, 0, 0, 1);
    step(1, 0, 1, 32'h102, 1);
`ifdef MISALIGN_CHECK_EN
    repeat (5) step(1, 0, 0, 0, 1);
    check("misalign_fault", FetchFault, 1);
    check("misalign_noreq", ImemReq, 0);
`else
    wait_valid();
    check("misalign_ignored_pcd", PCD, 32'h100);
`endif
    do_reset();
    repeat (20) step(1, 0, 0, 0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
